// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and constants for the decode-stage issue/interlock controller.
//   sb_entry_t : one scoreboard stage {v, we, dst, wz}
//   hz_state_t : controller state {RUN, DRAIN, HALTED}
//   REG_ZERO   : architectural constant-zero register
package hazard_pkg;

   typedef struct packed {
      logic       v;    // stage holds an issued instruction
      logic       we;   // instruction writes dst (never set for R0)
      logic [3:0] dst;  // destination register
      logic       wz;   // instruction updates the zero flag
   } sb_entry_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } hz_state_t;

   localparam logic [3:0] REG_ZERO = 4'd0;

   // One source port against one scoreboard entry; R0 reads never conflict.
   function automatic logic src_hit(sb_entry_t e, logic re, logic [3:0] addr);
      return e.v & e.we & re & (addr != REG_ZERO) & (e.dst == addr);
   endfunction

endpackage

// File: rtl/hazard_ctrl_sb_pipe.sv
// sb_pipe
//   Scoreboard shift register: stage 0 loads the entry for the instruction
//   entering execute, every stage advances each cycle, the last stage retires.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset (clears all stages)
//     load       : entry written into stage 0 at the next edge
//     entries    : all stages, index 0 = youngest
//     empty_next : no valid entry remains after the next edge (only the
//                  retiring last stage may be valid, and load is a bubble)
module sb_pipe
   import hazard_pkg::*;
#(
   parameter int unsigned DEPTH = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  sb_entry_t               load,
   output sb_entry_t [DEPTH-1:0]   entries,
   output logic                    empty_next
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entries <= '0;
      end else begin
         entries[0] <= load;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            entries[k] <= entries[k-1];
         end
      end
   end

   always_comb begin
      empty_next = ~load.v;
      for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
         if (entries[k].v) empty_next = 1'b0;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Issue/interlock controller beside the decode stage of the 16-bit core.
//   Tracks in-flight register and zero-flag writes in a WB_LAT-deep
//   scoreboard, stalls decode on a read-after-write hazard, suppresses issue
//   on a taken-branch flush, and sequences halt (drain, then sticky halted).
//   Parameters:
//     WB_LAT    : cycles from issue to register-file write (scoreboard depth)
//     WB_BYPASS : 1 = register file forwards a same-cycle write, so the last
//                 stage is not checked
//   Ports:
//     clk, rst                 : clock, asynchronous active-high reset
//     id_valid                 : decode holds a valid instruction
//     id_re0/id_re1            : source read enables
//     id_p0_addr/id_p1_addr    : source register addresses
//     id_we, id_dst_addr       : destination write enable / address
//     id_rd_zr, id_wr_zr       : consumes / updates the zero flag
//     id_hlt                   : instruction is hlt
//     flush                    : taken branch in execute, kill decode
//     stall                    : hold PC and IF/ID, bubble into execute
//     issue                    : decode instruction enters execute next edge
//     halted                   : sticky halt indication
//     inflight                 : valid scoreboard entries, saturating at 3
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned WB_LAT    = 3,
   parameter int unsigned WB_BYPASS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic       id_re0,
   input  logic       id_re1,
   input  logic [3:0] id_p0_addr,
   input  logic [3:0] id_p1_addr,
   input  logic       id_we,
   input  logic [3:0] id_dst_addr,
   input  logic       id_rd_zr,
   input  logic       id_wr_zr,
   input  logic       id_hlt,
   input  logic       flush,
   output logic       stall,
   output logic       issue,
   output logic       halted,
   output logic [1:0] inflight
);

   // Number of stages that can still hazard against a decode read.
   localparam int unsigned CHK_STAGES = WB_LAT - WB_BYPASS;

   sb_entry_t [WB_LAT-1:0] entries;
   sb_entry_t              load;
   logic                   empty_next;
   logic                   raw;
   hz_state_t              state, state_nxt;
   int unsigned            cnt;

   sb_pipe #(
      .DEPTH (WB_LAT)
   ) u_sb_pipe (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .entries    (entries),
      .empty_next (empty_next)
   );

   // Read-after-write check over the stages not covered by the bypass.
   always_comb begin
      raw = 1'b0;
      for (int unsigned k = 0; k < CHK_STAGES; k++) begin
         if (src_hit(entries[k], id_re0, id_p0_addr) |
             src_hit(entries[k], id_re1, id_p1_addr) |
             (entries[k].v & entries[k].wz & id_rd_zr)) begin
            raw = 1'b1;
         end
      end
   end

   // Flush only blocks issue; stall keeps following raw so fetch can
   // arbitrate the two itself.
   always_comb begin
      stall  = 1'b1;
      issue  = 1'b0;
      halted = 1'b0;
      case (state)
         RUN: begin
            stall = id_valid & raw;
            issue = id_valid & ~raw & ~flush;
         end
         HALTED: halted = 1'b1;
         default: ;
      endcase
   end

   // Writes to R0 are dropped here so the compare never needs to mask them.
   always_comb begin
      load     = '0;
      load.v   = issue;
      load.we  = issue & id_we & (id_dst_addr != REG_ZERO);
      load.dst = id_dst_addr;
      load.wz  = issue & id_wr_zr;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (issue & id_hlt) state_nxt = DRAIN;
         DRAIN:   if (empty_next) state_nxt = HALTED;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      cnt = 0;
      for (int unsigned k = 0; k < WB_LAT; k++) begin
         cnt = cnt + 32'(entries[k].v);
      end
      inflight = (cnt >= 3) ? 2'd3 : cnt[1:0];
   end

endmodule
